// File: rtl/md_unit_pkg.sv
// Shared MDU opcode constants, default latencies and result payload type.
package md_unit_pkg;

    localparam int unsigned MD_OP_W  = 4;
    localparam int unsigned MD_DATA_W = 32;
    localparam int unsigned MD_CNT_W = 4;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    localparam logic [MD_OP_W-1:0] nop_MDU   = 4'd0;
    localparam logic [MD_OP_W-1:0] mult_MDU  = 4'd1;
    localparam logic [MD_OP_W-1:0] multu_MDU = 4'd2;
    localparam logic [MD_OP_W-1:0] div_MDU   = 4'd3;
    localparam logic [MD_OP_W-1:0] divu_MDU  = 4'd4;
    localparam logic [MD_OP_W-1:0] mfhi_MDU  = 4'd5;
    localparam logic [MD_OP_W-1:0] mflo_MDU  = 4'd6;
    localparam logic [MD_OP_W-1:0] mthi_MDU  = 4'd7;
    localparam logic [MD_OP_W-1:0] mtlo_MDU  = 4'd8;

    typedef struct packed {
        logic [MD_DATA_W-1:0] hi;
        logic [MD_DATA_W-1:0] lo;
    } md_res_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // True for opcodes that launch a multi-cycle operation.
    function automatic logic is_md_op(input logic [MD_OP_W-1:0] op);
        return (op == mult_MDU) || (op == multu_MDU) ||
               (op == div_MDU)  || (op == divu_MDU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the pending {hi, lo} result.
module md_arith
    import md_unit_pkg::*;
(
    input  logic [MD_OP_W-1:0]   op_i,
    input  logic [MD_DATA_W-1:0] a_i,
    input  logic [MD_DATA_W-1:0] b_i,
    output md_res_t              res_o,
    output logic                 div0_o
);

    logic [63:0]          prod_s;
    logic [63:0]          prod_u;
    logic [MD_DATA_W-1:0] abs_a;
    logic [MD_DATA_W-1:0] abs_b;
    logic [MD_DATA_W-1:0] div_b;
    logic [MD_DATA_W-1:0] q_u;
    logic [MD_DATA_W-1:0] r_u;
    logic [MD_DATA_W-1:0] q_s_mag;
    logic [MD_DATA_W-1:0] r_s_mag;

    // Products, magnitudes and both flavours of quotient/remainder.
    always_comb begin
        prod_s  = 64'({{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i});
        prod_u  = 64'({32'd0, a_i} * {32'd0, b_i});
        abs_a   = a_i[31] ? 32'(-a_i) : a_i;
        abs_b   = b_i[31] ? 32'(-b_i) : b_i;
        // Divisor forced non-zero so the datapath never divides by zero; div0 masks the result.
        div_b   = (b_i == '0) ? 32'd1 : b_i;
        q_u     = a_i / div_b;
        r_u     = a_i % div_b;
        q_s_mag = abs_a / ((abs_b == '0) ? 32'd1 : abs_b);
        r_s_mag = abs_a % ((abs_b == '0) ? 32'd1 : abs_b);
    end

    // Select the result for the current opcode; 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
    always_comb begin
        res_o  = '0;
        div0_o = 1'b0;
        case (op_i)
            mult_MDU:  res_o = prod_s;
            multu_MDU: res_o = prod_u;
            div_MDU: begin
                div0_o   = (b_i == '0);
                res_o.lo = (a_i[31] ^ b_i[31]) ? 32'(-q_s_mag) : q_s_mag;
                res_o.hi = a_i[31] ? 32'(-r_s_mag) : r_s_mag;
            end
            divu_MDU: begin
                div0_o   = (b_i == '0);
                res_o.lo = q_u;
                res_o.hi = r_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO with a busy countdown for latency.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [MD_DATA_W-1:0]  hi_q, hi_d, lo_q, lo_d;
    md_res_t               pend_q, pend_d;
    logic                  wr_en_q, wr_en_d;
    md_res_t               arith_res;
    logic                  arith_div0;

    md_arith u_arith (
        .op_i   (MDop),
        .a_i    (A),
        .b_i    (B),
        .res_o  (arith_res),
        .div0_o (arith_div0)
    );

    assign busy  = (state_q == MD_RUN);
    assign start = is_md_op(MDop) && !req && !busy;
    assign HI    = hi_q;
    assign LO    = lo_q;

    // Read port for mfhi/mflo; returns committed values even while busy.
    always_comb begin
        MDout = '0;
        if (MDop == mfhi_MDU) MDout = hi_q;
        else if (MDop == mflo_MDU) MDout = lo_q;
    end

    // Next-state: launch, countdown, commit, and mthi/mtlo writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        wr_en_d = wr_en_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_RUN;
                    pend_d  = arith_res;
                    wr_en_d = !arith_div0;
                    cnt_d   = ((MDop == mult_MDU) || (MDop == multu_MDU))
                              ? MD_CNT_W'(MULT_CYCLES) : MD_CNT_W'(DIV_CYCLES);
                end else if (!req && (MDop == mthi_MDU)) begin
                    hi_d = A;
                end else if (!req && (MDop == mtlo_MDU)) begin
                    lo_d = A;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q - MD_CNT_W'(1);
                if (cnt_q == MD_CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    if (wr_en_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
            wr_en_q <= wr_en_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  MDop;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    int unsigned n_checks;
    int unsigned n_fail;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .MDop  (MDop),
        .A     (A),
        .B     (B),
        .req   (req),
        .start (start),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO),
        .MDout (MDout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance one cycle; inputs are then changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an operation for one cycle, then return to nop.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned n_busy, input string tag,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi, old_lo;
        old_hi = HI;
        old_lo = LO;
        MDop = op; A = a; B = b; req = 1'b0;
        #1;
        chk({tag, "_start"}, 32'(start), 32'd1);
        tick();
        MDop = 4'd0; A = '0; B = '0;
        #1;
        for (int i = 0; i < int'(n_busy); i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_hi_hold"}, HI, old_hi);
            chk({tag, "_lo_hold"}, LO, old_lo);
            tick();
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; MDop = 4'd0; A = '0; B = '0; req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_start", 32'(start), 32'd0);

        run_op(4'd1, 32'hFFFFFFFD, 32'd7, 5, "mult", 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op(4'd2, 32'hFFFFFFFD, 32'd7, 5, "multu", 32'h00000006, 32'hFFFFFFEB);
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, "div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(4'd4, 32'd7, 32'd2, 10, "divu", 32'd1, 32'd3);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, "div_ovf", 32'd0, 32'h80000000);
        run_op(4'd3, 32'd7, 32'hFFFFFFFE, 10, "div_pos_neg", 32'd1, 32'hFFFFFFFD);

        // Preload via mthi/mtlo, then divide by zero leaves them intact.
        MDop = 4'd7; A = 32'h11; tick();
        MDop = 4'd8; A = 32'h22; tick();
        MDop = 4'd0; #1;
        chk("mt_hi", HI, 32'h11);
        chk("mt_lo", LO, 32'h22);
        run_op(4'd3, 32'd5, 32'd0, 10, "div0", 32'h11, 32'h22);

        // mult with req blocks start.
        MDop = 4'd1; A = 32'd3; B = 32'd4; req = 1'b1;
        #1;
        chk("req_start", 32'(start), 32'd0);
        tick();
        MDop = 4'd0; req = 1'b0;
        #1;
        chk("req_busy", 32'(busy), 32'd0);
        tick();
        chk("req_hi", HI, 32'h11);
        chk("req_lo", LO, 32'h22);

        // mthi with req is suppressed.
        MDop = 4'd7; A = 32'h1234; req = 1'b1;
        tick();
        req = 1'b0; MDop = 4'd0;
        #1;
        chk("mthi_req_hi", HI, 32'h11);

        // mthi then mfhi/mflo read-back.
        MDop = 4'd7; A = 32'h1234;
        tick();
        MDop = 4'd5; A = '0;
        #1;
        chk("mfhi", MDout, 32'h1234);
        MDop = 4'd6;
        #1;
        chk("mflo", MDout, 32'h22);
        MDop = 4'd9;
        #1;
        chk("op9_start", 32'(start), 32'd0);
        chk("op9_mdout", MDout, 32'd0);

        // mfhi while busy returns the old value; reset in 3rd busy cycle aborts.
        MDop = 4'd4; A = 32'd100; B = 32'd7;
        tick();
        MDop = 4'd5; A = '0; B = '0;
        #1;
        chk("mf_busy_start", 32'(start), 32'd0);
        chk("mf_busy", MDout, 32'h1234);
        tick();
        tick();
        chk("rst_mid_busy", 32'(busy), 32'd1);
        MDop = 4'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_hi", HI, 32'd0);
        chk("rst2_lo", LO, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("rst2_hi_late", HI, 32'd0);
        chk("rst2_lo_late", LO, 32'd0);
        chk("rst2_busy_late", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
